// File: rtl/alu_operand_stage_pkg.sv
// rtl/alu_operand_stage_pkg.sv - shared encodings and defaults for the ALU operand stage
package alu_operand_stage_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [1:0] IMM_SIGN  = 2'b00;
    localparam logic [1:0] IMM_ZERO  = 2'b01;
    localparam logic [1:0] IMM_UPPER = 2'b10;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

endpackage

// File: rtl/alu_operand_stage_fwd_unit.sv
// rtl/alu_operand_stage_fwd_unit.sv - combinational EX/MEM and MEM/WB forwarding select for one operand
module alu_operand_stage_fwd_unit
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              exmem_wr_en,
    input  logic [REG_AW-1:0] exmem_waddr,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic              memwb_wr_en,
    input  logic [REG_AW-1:0] memwb_waddr,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] data
);

    logic src_nonzero;
    logic exmem_hit;
    logic memwb_hit;

    // Register 0 is hardwired, so a write to it must never be forwarded.
    assign src_nonzero = (src_addr != '0);
    assign exmem_hit   = exmem_wr_en && (exmem_waddr == src_addr) && src_nonzero;
    assign memwb_hit   = memwb_wr_en && (memwb_waddr == src_addr) && src_nonzero;

    always_comb begin
        sel  = FWD_RF;
        data = rf_data;
        if (exmem_hit) begin
            sel  = FWD_EXMEM;
            data = exmem_data;
        end else if (memwb_hit) begin
            sel  = FWD_MEMWB;
            data = memwb_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX operand resolve, immediate select and forwarding-event counter
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMM_W  = 16,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        imm_mode,
    input  logic              alu_in_sel,
    input  logic              exmem_wr_en,
    input  logic [REG_AW-1:0] exmem_waddr,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic              memwb_wr_en,
    input  logic [REG_AW-1:0] memwb_waddr,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [DATA_W-1:0] store_data,
    output logic              out_valid,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  fwd_count
);

    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] ext_imm;
    logic [DATA_W-1:0] op2;
    logic              a_hit;
    logic              b_hit;
    logic [1:0]        cnt_inc;
    logic [CNT_W:0]    cnt_sum;
    logic [CNT_W-1:0]  cnt_next;

    alu_operand_stage_fwd_unit #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_a (
        .src_addr    (rs_addr),
        .rf_data     (rf_rd1),
        .exmem_wr_en (exmem_wr_en),
        .exmem_waddr (exmem_waddr),
        .exmem_data  (exmem_data),
        .memwb_wr_en (memwb_wr_en),
        .memwb_waddr (memwb_waddr),
        .memwb_data  (memwb_data),
        .sel         (sel_a),
        .data        (fwd_a)
    );

    alu_operand_stage_fwd_unit #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_b (
        .src_addr    (rt_addr),
        .rf_data     (rf_rd2),
        .exmem_wr_en (exmem_wr_en),
        .exmem_waddr (exmem_waddr),
        .exmem_data  (exmem_data),
        .memwb_wr_en (memwb_wr_en),
        .memwb_waddr (memwb_waddr),
        .memwb_data  (memwb_data),
        .sel         (sel_b),
        .data        (fwd_b)
    );

    // Mode 11 is reserved and falls back to sign extension.
    always_comb begin
        case (imm_mode)
            IMM_ZERO:  ext_imm = DATA_W'(imm);
            IMM_UPPER: ext_imm = DATA_W'(imm) << (DATA_W - IMM_W);
            default:   ext_imm = DATA_W'($signed(imm));
        endcase
    end

    assign op2 = alu_in_sel ? ext_imm : fwd_b;

    // Operand B only counts as a forwarding event when the ALU actually consumes it.
    assign a_hit    = (sel_a != FWD_RF);
    assign b_hit    = (sel_b != FWD_RF) && !alu_in_sel;
    assign cnt_inc  = in_valid ? ({1'b0, a_hit} + {1'b0, b_hit}) : 2'b00;
    assign cnt_sum  = {1'b0, fwd_count} + (CNT_W + 1)'(cnt_inc);
    assign cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_in1    <= '0;
            alu_in2    <= '0;
            store_data <= '0;
            out_valid  <= 1'b0;
            fwd_a_sel  <= FWD_RF;
            fwd_b_sel  <= FWD_RF;
            fwd_count  <= '0;
        end else if (flush) begin
            alu_in1    <= '0;
            alu_in2    <= '0;
            store_data <= '0;
            out_valid  <= 1'b0;
            fwd_a_sel  <= FWD_RF;
            fwd_b_sel  <= FWD_RF;
        end else if (!stall) begin
            alu_in1    <= fwd_a;
            alu_in2    <= op2;
            store_data <= fwd_b;
            out_valid  <= in_valid;
            fwd_a_sel  <= in_valid ? sel_a : FWD_RF;
            fwd_b_sel  <= in_valid ? sel_b : FWD_RF;
            fwd_count  <= cnt_next;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - randomized self-checking bench for alu_operand_stage
module tb_alu_operand_stage;

    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;
    logic [IMM_W-1:0]  imm;
    logic [1:0]        imm_mode;
    logic              alu_in_sel;
    logic              exmem_wr_en;
    logic [REG_AW-1:0] exmem_waddr;
    logic [DATA_W-1:0] exmem_data;
    logic              memwb_wr_en;
    logic [REG_AW-1:0] memwb_waddr;
    logic [DATA_W-1:0] memwb_data;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic [DATA_W-1:0] store_data;
    logic              out_valid;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [CNT_W-1:0]  fwd_count;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] e_in1, e_in2, e_sd;
    logic              e_v;
    logic [1:0]        e_sa, e_sb;
    int                e_cnt;

    alu_operand_stage #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .in_valid    (in_valid),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rf_rd1      (rf_rd1),
        .rf_rd2      (rf_rd2),
        .imm         (imm),
        .imm_mode    (imm_mode),
        .alu_in_sel  (alu_in_sel),
        .exmem_wr_en (exmem_wr_en),
        .exmem_waddr (exmem_waddr),
        .exmem_data  (exmem_data),
        .memwb_wr_en (memwb_wr_en),
        .memwb_waddr (memwb_waddr),
        .memwb_data  (memwb_data),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .store_data  (store_data),
        .out_valid   (out_valid),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .fwd_count   (fwd_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic ref_operand(input int addr, input logic [DATA_W-1:0] rf,
                               output logic [DATA_W-1:0] val, output int src);
        if (addr != 0 && exmem_wr_en && int'(exmem_waddr) == addr) begin
            val = exmem_data; src = 1;
        end else if (addr != 0 && memwb_wr_en && int'(memwb_waddr) == addr) begin
            val = memwb_data; src = 2;
        end else begin
            val = rf; src = 0;
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_imm(input longint raw, input int mode);
        longint v;
        if (mode == 1)
            v = raw;
        else if (mode == 2)
            v = raw * (longint'(1) << (DATA_W - IMM_W));
        else if (raw >= (longint'(1) << (IMM_W - 1)))
            v = raw + (longint'(1) << DATA_W) - (longint'(1) << IMM_W);
        else
            v = raw;
        return v[DATA_W-1:0];
    endfunction

    task automatic model_update();
        logic [DATA_W-1:0] va, vb;
        int sa, sb, inc;
        ref_operand(int'(rs_addr), rf_rd1, va, sa);
        ref_operand(int'(rt_addr), rf_rd2, vb, sb);
        if (rst) begin
            e_in1 = '0; e_in2 = '0; e_sd = '0; e_v = 1'b0; e_sa = 0; e_sb = 0; e_cnt = 0;
        end else if (flush) begin
            e_in1 = '0; e_in2 = '0; e_sd = '0; e_v = 1'b0; e_sa = 0; e_sb = 0;
        end else if (!stall) begin
            e_in1 = va;
            e_in2 = alu_in_sel ? ref_imm(longint'(imm), int'(imm_mode)) : vb;
            e_sd  = vb;
            e_v   = in_valid;
            e_sa  = in_valid ? 2'(sa) : 2'd0;
            e_sb  = in_valid ? 2'(sb) : 2'd0;
            inc   = 0;
            if (in_valid) begin
                if (sa != 0) inc++;
                if (sb != 0 && !alu_in_sel) inc++;
            end
            e_cnt = (e_cnt + inc > CNT_MAX) ? CNT_MAX : e_cnt + inc;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check("alu_in1", alu_in1, e_in1);
        check("alu_in2", alu_in2, e_in2);
        check("store_data", store_data, e_sd);
        check("out_valid", DATA_W'(out_valid), DATA_W'(e_v));
        check("fwd_a_sel", DATA_W'(fwd_a_sel), DATA_W'(e_sa));
        check("fwd_b_sel", DATA_W'(fwd_b_sel), DATA_W'(e_sb));
        check("fwd_count", DATA_W'(fwd_count), DATA_W'(e_cnt));
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; in_valid = 0; rs_addr = 0; rt_addr = 0;
        rf_rd1 = 0; rf_rd2 = 0; imm = 0; imm_mode = 0; alu_in_sel = 0;
        exmem_wr_en = 0; exmem_waddr = 0; exmem_data = 0;
        memwb_wr_en = 0; memwb_waddr = 0; memwb_data = 0;
    endtask

    initial begin
        logic [DATA_W-1:0] imm_exp [3];
        imm_exp[0] = 32'hFFFF_8001;
        imm_exp[1] = 32'h0000_8001;
        imm_exp[2] = 32'h8001_0000;
        e_cnt = 0;
        clear_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
        step();
        check("reset_count", DATA_W'(fwd_count), 0);

        in_valid = 1; rs_addr = 3; rt_addr = 4; rf_rd1 = 32'h11; rf_rd2 = 32'h22;
        exmem_wr_en = 1; exmem_waddr = 3; exmem_data = 32'hAA;
        memwb_wr_en = 1; memwb_waddr = 3; memwb_data = 32'hBB;
        step();
        check("fwd_prio_in1", alu_in1, 32'hAA);
        check("fwd_prio_in2", alu_in2, 32'h22);
        check("fwd_prio_sel", DATA_W'(fwd_a_sel), 1);
        check("fwd_prio_cnt", DATA_W'(fwd_count), 1);

        rs_addr = 0; exmem_waddr = 0; rf_rd1 = 0;
        step();
        check("r0_in1", alu_in1, 0);
        check("r0_cnt", DATA_W'(fwd_count), 1);

        exmem_wr_en = 0; memwb_wr_en = 0; alu_in_sel = 1; imm = 16'h8001; rf_rd2 = 32'h1234_5678;
        for (int m = 0; m < 3; m++) begin
            imm_mode = 2'(m);
            step();
            check("imm_ext", alu_in2, imm_exp[m]);
            check("imm_store", store_data, 32'h1234_5678);
        end

        stall = 1; flush = 1;
        step();
        check("flush_valid", DATA_W'(out_valid), 0);
        flush = 0; rf_rd1 = 32'hDEAD;
        step();
        stall = 0;

        rst = 1;
        step();
        rst = 0; in_valid = 1; alu_in_sel = 0; rs_addr = 1; rt_addr = 2;
        exmem_wr_en = 1; exmem_waddr = 1; exmem_data = 32'h5;
        memwb_wr_en = 1; memwb_waddr = 2; memwb_data = 32'h6;
        for (int i = 0; i < 7; i++) step();
        check("sat_pre", DATA_W'(fwd_count), 14);
        step();
        check("sat_hit", DATA_W'(fwd_count), 15);
        step();
        check("sat_hold", DATA_W'(fwd_count), 15);

        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            stall       = ($urandom_range(0, 7) == 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            rs_addr     = REG_AW'($urandom_range(0, 3));
            rt_addr     = REG_AW'($urandom_range(0, 3));
            rf_rd1      = $urandom;
            rf_rd2      = $urandom;
            imm         = IMM_W'($urandom);
            imm_mode    = 2'($urandom_range(0, 3));
            alu_in_sel  = 1'($urandom_range(0, 1));
            exmem_wr_en = 1'($urandom_range(0, 1));
            exmem_waddr = REG_AW'($urandom_range(0, 3));
            exmem_data  = $urandom;
            memwb_wr_en = 1'($urandom_range(0, 1));
            memwb_waddr = REG_AW'($urandom_range(0, 3));
            memwb_data  = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Parametrised successor of the ALU operand-2 select for the pipelined datapath. It sits at the ID/EX boundary. It resolves both ALU operands with EX/MEM and MEM/WB forwarding, and selects between the register and an extended immediate (sign, zero or upper extension). It registers the results into the EX stage with stall/flush control and keeps a saturating count of forwarding events for performance debug.

Parameters:
DATA_W, 32, datapath width
IMM_W, 16, raw immediate width; must be <= DATA_W
REG_AW, 5, register address width
CNT_W, 16, width of the forwarding-event counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold all registered outputs
flush  in  1  insert a bubble
in_valid  in  1  ID-stage instruction is valid
rs_addr  in  REG_AW  source register A
rt_addr  in  REG_AW  source register B
rf_rd1  in  DATA_W  register-file read data A
rf_rd2  in  DATA_W  register-file read data B
imm  in  IMM_W  raw immediate
imm_mode  in  2  00 sign-ext, 01 zero-ext, 10 upper (imm << (DATA_W-IMM_W)), 11 treated as 00
alu_in_sel  in  1  1: operand 2 = extended imm; 0: forwarded B
exmem_wr_en  in  1  EX/MEM stage will write the register file
exmem_waddr  in  REG_AW  EX/MEM destination
exmem_data  in  DATA_W  EX/MEM result
memwb_wr_en  in  1  MEM/WB stage will write the register file
memwb_waddr  in  REG_AW  MEM/WB destination
memwb_data  in  DATA_W  MEM/WB result
alu_in1  out  DATA_W  registered operand 1
alu_in2  out  DATA_W  registered operand 2
store_data  out  DATA_W  registered forwarded B (for stores)
out_valid  out  1  registered valid
fwd_a_sel  out  2  registered: 00 RF, 01 EX/MEM, 10 MEM/WB
fwd_b_sel  out  2  registered, same encoding as fwd_a_sel
fwd_count  out  CNT_W  saturating count of forwarded operands

Behaviour:
- Combinational forwarding for operand A, with operand B identical using rt_addr/rf_rd2:
  - EX/MEM hit: exmem_wr_en && exmem_waddr==rs_addr && rs_addr!=0.
  - MEM/WB hit: memwb_wr_en && memwb_waddr==rs_addr && rs_addr!=0.
  - Priority is EX/MEM > MEM/WB > RF.
  - Register 0 is never forwarded; rf_rd1 is used for it.
- Immediate extension is combinational. Sign-extend replicates imm[IMM_W-1]. Upper mode fills the low DATA_W-IMM_W bits with zeros.
- Operand 2 = alu_in_sel ? ext_imm : fwdB. store_data always takes fwdB, independent of alu_in_sel.
- Latency is 1 cycle from ID inputs to registered outputs.
- Per-edge update priority:
  - rst: all outputs 0, including fwd_count and the sel outputs.
  - flush: out_valid=0; alu_in1, alu_in2, store_data and the sel outputs are set to 0; fwd_count is unchanged. Flush wins over stall.
  - stall: all registers hold, including fwd_count.
  - Otherwise: load the computed values and set out_valid=in_valid.
- fwd_count increments on a non-stalled, non-flushed load with in_valid=1:
  - +1 if operand A was forwarded.
  - +1 if operand B was forwarded and alu_in_sel=0.
  - The increment is 0, 1 or 2 per cycle and saturates at 2^CNT_W-1. There is no wrap, and a +2 from max-1 gives max.
- When in_valid=0 the data still loads but sel outputs are forced to 00 and the counter is not incremented.
- Reset mid-stall or mid-flush: rst dominates and the next cycle starts clean.
- Both forwarding stages hitting the same register at once resolves to the EX/MEM value.

Decomposition:
- Shared package holds:
  - FWD_RF/FWD_EXMEM/FWD_MEMWB (2-bit)
  - IMM_SIGN/IMM_ZERO/IMM_UPPER (2-bit)
  - default DATA_W/REG_AW
- One natural sub-module, fwd_unit: the combinational forwarding compare. It is instantiated twice (A and B) and returns the sel code and data.
- Immediate extension stays inline.

Test Plan:
1. rst=1 for 2 cycles, then idle with in_valid=0 -> all outputs 0, fwd_count=0.
2. rs=3, rt=4, rf_rd1=0x11, rf_rd2=0x22, exmem waddr=3/data=0xAA, memwb waddr=3/data=0xBB, alu_in_sel=0 -> next cycle alu_in1=0xAA, alu_in2=0x22, fwd_a_sel=01, fwd_b_sel=00, fwd_count=1.
3. rs=0, exmem_wr_en=1, exmem waddr=0, rf_rd1=0 -> alu_in1=0, fwd_a_sel=00, counter unchanged.
4. imm=0x8001 with alu_in_sel=1 in each mode:
   - mode 00 -> alu_in2=0xFFFF8001.
   - mode 01 -> alu_in2=0x00008001.
   - mode 10 -> alu_in2=0x80010000.
   - In all three, store_data still equals forwarded B.
5. Load values, then assert stall=1 and flush=1 in the same cycle -> out_valid=0 and outputs 0. A further cycle with stall=1 alone -> outputs and counter hold.
6. CNT_W=4, preload to 14, then a cycle with both operands forwarded -> fwd_count=15. Repeat -> stays 15.
